z88_sram_arbiter: RTL



---
 rtl/z88_sram_arb_pkg.sv | 21 ++
 rtl/z88_sram_arb_pick.sv | 23 ++
 rtl/z88_sram_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/z88_sram_arb_pkg.sv
// Shared state encoding, port indices and defaults for the Z88 SRAM arbiter.
package z88_sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_END    = 2'd3
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam int WAIT_CYCLES_DEFAULT = 1;

   // Select the addressed byte lane out of a 16-bit SRAM word.
   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/z88_sram_arb_pick.sv
// Combinational winner select between the two requesters.
// The round-robin pointer (last granted port) is owned by the parent.
module z88_sram_arb_pick
   import z88_sram_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic gnt_vld_o,
   output logic gnt_port_o
);

   always_comb begin
      gnt_vld_o  = req0_i | req1_i;
      gnt_port_o = PORT_CPU;
      if (req0_i && req1_i) begin
         gnt_port_o = ~last_i;
      end else if (req1_i) begin
         gnt_port_o = PORT_AUX;
      end
   end

endmodule

// File: rtl/z88_sram_arbiter.sv
// Two-port byte-wide arbiter in front of a 16-bit asynchronous SRAM.
// Define Z88_SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module z88_sram_arbiter
   import z88_sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] a0,
   input  logic [ADDR_W-1:0] a1,
   input  logic [7:0]        di0,
   input  logic [7:0]        di1,
   output logic              ack0,
   output logic              ack1,
   output logic [7:0]        do0,
   output logic [7:0]        do1,
   output logic [ADDR_W-2:0] sram_addr,
   input  logic [15:0]       sram_dq_i,
   output logic [15:0]       sram_dq_o,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

   localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

   arb_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic              lane_q, lane_d;
   logic [ADDR_W-2:0] addr_q, addr_d;
   logic [15:0]       dq_o_q, dq_o_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic [7:0]        do0_q, do0_d, do1_q, do1_d;

   logic              gnt_vld, gnt_port, rr_last;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_a;
   logic [7:0]        sel_di;

`ifdef Z88_SRAM_ARB_RR_EN
   logic rr_last_q;
   // Pointer holds the last granted port; reset value makes port 0 win the first collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= PORT_AUX;
      end else if (state_q == ST_IDLE && gnt_vld) begin
         rr_last_q <= gnt_port;
      end
   end
   assign rr_last = rr_last_q;
`else
   assign rr_last = PORT_AUX;
`endif

   z88_sram_arb_pick u_pick (
      .req0_i     (req0),
      .req1_i     (req1),
      .last_i     (rr_last),
      .gnt_vld_o  (gnt_vld),
      .gnt_port_o (gnt_port)
   );

   assign sel_we = (gnt_port == PORT_AUX) ? we1 : we0;
   assign sel_a  = (gnt_port == PORT_AUX) ? a1  : a0;
   assign sel_di = (gnt_port == PORT_AUX) ? di1 : di0;

   // Next values describe the outputs of the state being entered, so every pin is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      port_d  = port_q;
      we_d    = we_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      dq_o_d  = dq_o_q;
      dq_oe_d = dq_oe_q;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      ub_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      do0_d   = do0_q;
      do1_d   = do1_q;

      case (state_q)
         ST_IDLE: begin
            dq_oe_d = 1'b0;
            if (gnt_vld) begin
               state_d = ST_SETUP;
               port_d  = gnt_port;
               we_d    = sel_we;
               lane_d  = sel_a[0];
               addr_d  = sel_a[ADDR_W-1:1];
               dq_o_d  = {sel_di, sel_di};
               dq_oe_d = sel_we;
               ce_n_d  = 1'b0;
               ub_n_d  = ~sel_a[0];
               lb_n_d  = sel_a[0];
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = WAIT_L;
            ce_n_d  = 1'b0;
            oe_n_d  = we_q;
            we_n_d  = ~we_q;
            ub_n_d  = ~lane_q;
            lb_n_d  = lane_q;
         end
         ST_ACCESS: begin
            ub_n_d = ~lane_q;
            lb_n_d = lane_q;
            if (cnt_q <= 4'd1) begin
               state_d = ST_END;
               if (port_q == PORT_CPU) begin
                  ack0_d = 1'b1;
                  if (!we_q) do0_d = lane_byte(sram_dq_i, lane_q);
               end else begin
                  ack1_d = 1'b1;
                  if (!we_q) do1_d = lane_byte(sram_dq_i, lane_q);
               end
            end else begin
               cnt_d  = cnt_q - 4'd1;
               ce_n_d = 1'b0;
               oe_n_d = we_q;
               we_n_d = ~we_q;
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
            dq_oe_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         port_q  <= PORT_CPU;
         we_q    <= 1'b0;
         lane_q  <= 1'b0;
         addr_q  <= '0;
         dq_o_q  <= 16'h0000;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         do0_q   <= 8'h00;
         do1_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         port_q  <= port_d;
         we_q    <= we_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         dq_o_q  <= dq_o_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         ub_n_q  <= ub_n_d;
         lb_n_q  <= lb_n_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         do0_q   <= do0_d;
         do1_q   <= do1_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign do0        = do0_q;
   assign do1        = do1_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_ub_n  = ub_n_q;
   assign sram_lb_n  = lb_n_q;

endmodule
